// File: rtl/fc_pkg.sv
// Shared types and constants for the fully-connected node datapath.
package fc_pkg;

    typedef logic signed [7:0]  act_t;
    typedef logic signed [15:0] acc_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_FETCH,
        R_SEND
    } rd_state_t;

    localparam int ACT_MAX = 127;
    localparam int ACT_MIN = -128;

endpackage

// File: rtl/act_requant.sv
// Combinational requantizer: optional ReLU, round-half-up arithmetic shift, saturate to 8 bits.
module act_requant
    import fc_pkg::*;
(
    input  acc_t       x_i,
    input  logic       relu_en_i,
    input  logic [3:0] shift_amt_i,
    output act_t       y_o,
    output logic       sat_o
);

    localparam logic signed [16:0] HI = 17'(ACT_MAX);
    localparam logic signed [16:0] LO = 17'(ACT_MIN);

    logic signed [16:0] v;
    logic signed [16:0] sum;
    logic signed [16:0] r;

    always_comb begin
        v     = (relu_en_i && x_i < 0) ? 17'sd0 : $signed({x_i[15], x_i});
        sum   = v;
        r     = v;
        if (shift_amt_i != 4'd0) begin
            // One extra bit keeps the rounding add from wrapping at +32767.
            sum = v + (17'sd1 <<< (shift_amt_i - 4'd1));
            r   = sum >>> shift_amt_i;
        end
        sat_o = 1'b0;
        y_o   = r[7:0];
        if (r > HI) begin
            y_o   = 8'(ACT_MAX);
            sat_o = 1'b1;
        end else if (r < LO) begin
            y_o   = 8'(ACT_MIN);
            sat_o = 1'b1;
        end
    end

endmodule

// File: rtl/fc_act_writeback.sv
// Requantizes node accumulations into a ping-pong activation buffer and streams full vectors out.
module fc_act_writeback
    import fc_pkg::*;
#(
    parameter int NODES = 200,
    parameter int DW    = 16,
    parameter int OW    = 8,
    parameter int IW    = $clog2(NODES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_x,
    output logic          in_ready,
    input  logic          relu_en,
    input  logic [3:0]    shift_amt,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] out_data,
    output logic [IW-1:0] out_idx,
    output logic          out_last,
    output logic          sat_pulse
);

    localparam logic [IW-1:0] LAST_IDX = IW'(NODES - 1);

    act_t          mem_q [2][NODES];
    logic [1:0]    full_q, full_d;
    logic          wr_bank_q, rd_bank_q;
    logic [IW-1:0] wr_cnt_q, out_idx_q, nxt_idx;
    logic          s1_valid_q, sat_pulse_q, out_valid_q;
    act_t          s1_data_q, rd_word_q, out_data_q;
    rd_state_t     rd_state_q, rd_state_d;

    act_t          rq_y;
    logic          rq_sat, accept, last_wr;
    logic          rd_issue, rd_load, rd_adv, rd_free;

    act_requant u_requant (
        .x_i         (acc_t'(in_x)),
        .relu_en_i   (relu_en),
        .shift_amt_i (shift_amt),
        .y_o         (rq_y),
        .sat_o       (rq_sat)
    );

    // Look-ahead: the element in stage 1 completes this bank, so the next accept lands in the other one.
    assign last_wr  = s1_valid_q && (wr_cnt_q == LAST_IDX);
    assign in_ready = !rst && !full_q[wr_bank_q] && !(last_wr && full_q[~wr_bank_q]);
    assign accept   = in_valid && in_ready;
    assign nxt_idx  = out_idx_q + IW'(1);

    always_comb begin
        rd_state_d = rd_state_q;
        rd_issue   = 1'b0;
        rd_load    = 1'b0;
        rd_adv     = 1'b0;
        rd_free    = 1'b0;
        case (rd_state_q)
            R_IDLE: begin
                if (full_q[rd_bank_q]) begin
                    rd_issue   = 1'b1;
                    rd_state_d = R_FETCH;
                end
            end
            R_FETCH: begin
                rd_load    = 1'b1;
                rd_state_d = R_SEND;
            end
            R_SEND: begin
                if (out_ready) begin
                    if (out_idx_q == LAST_IDX) begin
                        rd_free    = 1'b1;
                        rd_state_d = R_IDLE;
                    end else begin
                        rd_adv = 1'b1;
                    end
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    // Write side and read side never touch the same bank's flag on one edge.
    always_comb begin
        full_d = full_q;
        if (last_wr) full_d[wr_bank_q] = 1'b1;
        if (rd_free) full_d[rd_bank_q] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (s1_valid_q) mem_q[wr_bank_q][wr_cnt_q] <= s1_data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            sat_pulse_q <= 1'b0;
            wr_cnt_q    <= '0;
            wr_bank_q   <= 1'b0;
            full_q      <= 2'b00;
        end else begin
            s1_valid_q  <= accept;
            sat_pulse_q <= accept && rq_sat;
            full_q      <= full_d;
            if (accept) s1_data_q <= rq_y;
            if (s1_valid_q) begin
                if (last_wr) begin
                    wr_cnt_q  <= '0;
                    wr_bank_q <= ~wr_bank_q;
                end else begin
                    wr_cnt_q <= wr_cnt_q + IW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state_q  <= R_IDLE;
            rd_bank_q   <= 1'b0;
            rd_word_q   <= '0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            rd_state_q <= rd_state_d;
            if (rd_issue) rd_word_q <= mem_q[rd_bank_q][0];
            if (rd_load) begin
                out_data_q  <= rd_word_q;
                out_idx_q   <= '0;
                out_valid_q <= 1'b1;
            end
            // Prefetch straight into the output register to sustain one element per cycle.
            if (rd_adv) begin
                out_data_q <= mem_q[rd_bank_q][nxt_idx];
                out_idx_q  <= nxt_idx;
            end
            if (rd_free) begin
                out_valid_q <= 1'b0;
                out_idx_q   <= '0;
                rd_bank_q   <= ~rd_bank_q;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = OW'(out_data_q);
    assign out_idx   = out_idx_q;
    assign out_last  = out_valid_q && (out_idx_q == LAST_IDX);
    assign sat_pulse = sat_pulse_q;

endmodule

// File: tb/tb_fc_act_writeback.sv
// Directed bench for fc_act_writeback with NODES=4: expected outputs queued at accept, checked by a monitor.
module tb_fc_act_writeback;

  localparam int NODES = 4;
  localparam int IW    = 2;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [15:0]   in_x;
  logic          in_ready;
  logic          relu_en;
  logic [3:0]    shift_amt;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_data;
  logic [IW-1:0] out_idx;
  logic          out_last;
  logic          sat_pulse;

  fc_act_writeback #(.NODES(NODES), .DW(16), .OW(8), .IW(IW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_x      (in_x),
    .in_ready  (in_ready),
    .relu_en   (relu_en),
    .shift_amt (shift_amt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .sat_pulse (sat_pulse)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // scoreboard: {last, idx, data}
  logic [IW+8:0] exp_q[$];
  int errors = 0;
  int checks = 0;
  int sat_seen = 0;
  int hs_seen = 0;
  int exp_idx = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic push(input int d);
    logic [7:0] db;
    logic [IW-1:0] ib;
    db = 8'(d);
    ib = IW'(exp_idx);
    exp_q.push_back({(exp_idx == NODES - 1), ib, db});
    exp_idx = (exp_idx + 1) % NODES;
  endtask

  // monitor
  logic          prev_stall = 1'b0;
  logic [7:0]    prev_data;
  logic [IW-1:0] prev_idx;

  always @(negedge clk) begin
    logic [IW+8:0] e;
    logic [7:0] ed;
    logic [IW-1:0] ei;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (sat_pulse) sat_seen++;
      if (prev_stall) begin
        check("hold_valid", int'(out_valid), 1);
        check("hold_data", int'(out_data), int'(prev_data));
        check("hold_idx", int'(out_idx), int'(prev_idx));
      end
      if (out_valid && out_ready) begin
        hs_seen++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got data %0d idx %0d, expected none", $signed(out_data), out_idx);
        end else begin
          e  = exp_q.pop_front();
          ed = e[7:0];
          ei = e[IW+7:8];
          check("out_data", int'($signed(out_data)), int'($signed(ed)));
          check("out_idx", int'(out_idx), int'(ei));
          check("out_last", int'(out_last), int'(e[IW+8]));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_idx   = out_idx;
    end
  end

  // driver tasks
  task automatic send(input int x, input bit relu, input int sh, input int expd, input bit do_push);
    bit acc;
    acc = 1'b0;
    in_x      = 16'(x);
    relu_en   = relu;
    shift_amt = 4'(sh);
    in_valid  = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    in_valid = 1'b0;
    if (!acc) check("send_timeout", 0, 1);
    else if (do_push) push(expd);
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    check("drain_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_in_ready"}, int'(in_ready), 0);
    check({tag, "_out_valid"}, int'(out_valid), 0);
    check({tag, "_out_data"}, int'(out_data), 0);
    check({tag, "_out_idx"}, int'(out_idx), 0);
    check({tag, "_out_last"}, int'(out_last), 0);
    check({tag, "_sat_pulse"}, int'(sat_pulse), 0);
  endtask

  int sat0;
  int hs0;
  int accepts;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_x      = '0;
    relu_en   = 1'b0;
    shift_amt = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", int'(in_ready), 1);
    @(posedge clk);
    #1;

    // basic requant with one saturation
    sat0 = sat_seen;
    send(100, 0, 2, 25, 1);
    send(-50, 0, 2, -12, 1);
    send(300, 0, 2, 75, 1);
    send(1000, 0, 2, 127, 1);
    drain();
    check("sat_count_v1", sat_seen - sat0, 1);

    // ReLU, no shift
    sat0 = sat_seen;
    send(-50, 1, 0, 0, 1);
    send(-1, 1, 0, 0, 1);
    send(0, 1, 0, 0, 1);
    send(5, 1, 0, 5, 1);
    drain();
    check("sat_count_relu", sat_seen - sat0, 0);

    // rounding and extreme values
    sat0 = sat_seen;
    send(6, 0, 2, 2, 1);
    send(-6, 0, 2, -1, 1);
    send(32767, 0, 15, 1, 1);
    send(-32768, 0, 0, -128, 1);
    drain();
    check("sat_count_round", sat_seen - sat0, 1);

    // backpressure: both banks fill, ninth offer refused
    out_ready = 1'b0;
    accepts = 0;
    for (int i = 0; i < 10; i++) begin
      in_x      = 16'(i * 4);
      relu_en   = 1'b0;
      shift_amt = 4'd2;
      in_valid  = 1'b1;
      @(negedge clk);
      if (in_ready) begin
        accepts++;
        push(i);
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("bp_accepts", accepts, 8);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("bp_ready_low", int'(in_ready), 0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();

    // toggled out_ready while streaming
    hs0 = hs_seen;
    out_ready = 1'b0;
    send(40, 0, 2, 10, 1);
    send(44, 0, 2, 11, 1);
    send(48, 0, 2, 12, 1);
    send(52, 0, 2, 13, 1);
    for (int i = 0; i < 24; i++) begin
      out_ready = (i % 2 == 0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    drain();
    check("toggle_handshakes", hs_seen - hs0, 4);

    // reset mid-vector discards the partial bank
    send(7, 0, 0, 7, 0);
    send(8, 0, 0, 8, 0);
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("midreset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_idx = 0;
    hs0 = hs_seen;
    send(1, 0, 0, 1, 1);
    send(2, 0, 0, 2, 1);
    send(3, 0, 0, 3, 1);
    send(4, 0, 0, 4, 1);
    drain();
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("post_reset_handshakes", hs_seen - hs0, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
